// File: rtl/reg_file_32x32.sv
// reg_file_32x32: 2**ADDR_W x DATA_W register file with one synchronous write
// port and two combinational read ports. Register 0 always reads as zero.
// Optional feature: define REG_FILE_BYPASS_EN to forward the pending write data
// to a read port addressing the write target in the same cycle. Without the
// macro, reads show the stored value until the write edge.
module reg_file_32x32 #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b
);

    localparam int DEPTH = 2 ** ADDR_W;

    // Storage. Entry 0 is only ever cleared; the read path also masks it.
    logic [DATA_W-1:0] regs_q [DEPTH];

    // One-hot write select; address 0 never gets a select line.
    logic [DEPTH-1:0] wr_sel;

    // Decode the write address into a one-hot select, dropping writes to reg 0.
    always_comb begin
        wr_sel = '0;
        if (we && (waddr != '0)) begin
            wr_sel[waddr] = 1'b1;
        end
    end

    // Register update: reset clears everything and overrides any write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                if (wr_sel[i]) begin
                    regs_q[i] <= wdata;
                end
            end
        end
    end

`ifdef REG_FILE_BYPASS_EN
    // A write is forwarded only when it will actually land in a register.
    logic fwd_valid;
    assign fwd_valid = we && !reset && (waddr != '0);
`endif

    // Stored value for an address, with reg 0 forced to zero.
    function automatic logic [DATA_W-1:0] stored(input logic [ADDR_W-1:0] addr);
        if (addr == '0) begin
            return '0;
        end
        return regs_q[addr];
    endfunction

    // Read port A: combinational, optionally forwarding the in-flight write.
    always_comb begin
        rdata_a = stored(raddr_a);
`ifdef REG_FILE_BYPASS_EN
        if (fwd_valid && (raddr_a == waddr)) begin
            rdata_a = wdata;
        end
`endif
    end

    // Read port B: identical structure, independent address.
    always_comb begin
        rdata_b = stored(raddr_b);
`ifdef REG_FILE_BYPASS_EN
        if (fwd_valid && (raddr_b == waddr)) begin
            rdata_b = wdata;
        end
`endif
    end

endmodule

// File: tb/tb_reg_file_32x32.sv
// Bench for reg_file_32x32: directed vector table, hand-written same-cycle
// read-of-write-target sequence, and a randomized phase against an array model.
// Compile with REG_FILE_BYPASS_EN defined to check the forwarding build.
module tb_reg_file_32x32;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int N  = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          we = 1'b0;
    logic [AW-1:0] waddr = '0;
    logic [DW-1:0] wdata = '0;
    logic [AW-1:0] raddr_a = '0;
    logic [AW-1:0] raddr_b = '0;
    logic [DW-1:0] rdata_a;
    logic [DW-1:0] rdata_b;

    int n_checks = 0;
    int n_passed = 0;

    // Reference contents: plain array, register 0 never written.
    logic [DW-1:0] model [N];

`ifdef REG_FILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    reg_file_32x32 #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk     (clk),
        .reset   (reset),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .raddr_a (raddr_a),
        .raddr_b (raddr_b),
        .rdata_a (rdata_a),
        .rdata_b (rdata_b)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, required finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string         name;
        bit            rst;
        bit            wen;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic [AW-1:0] ra;
        logic [AW-1:0] rb;
        logic [DW-1:0] exp_a;
        logic [DW-1:0] exp_b;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) begin
            n_passed++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One clock edge with the given controls; write is withdrawn after the edge.
    task automatic do_cycle(input bit rst, input bit wen, input logic [AW-1:0] wa,
                            input logic [DW-1:0] wd);
        @(negedge clk);
        reset = rst;
        we    = wen;
        waddr = wa;
        wdata = wd;
        @(posedge clk);
        #1;
        reset = 1'b0;
        we    = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                              input logic [DW-1:0] ea, input logic [DW-1:0] eb);
        raddr_a = ra;
        raddr_b = rb;
        #1;
        check({name, "_a"}, rdata_a, ea);
        check({name, "_b"}, rdata_b, eb);
    endtask

    // Expected read value given the model and the controls currently driven.
    function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] ra);
        if (BYPASS && we && !reset && (waddr != 0) && (ra == waddr)) begin
            return wdata;
        end
        return model[ra];
    endfunction

    task automatic reset_sweep(input string name);
        for (int i = 0; i < N; i++) begin
            read_check(name, AW'(i), AW'(N - 1 - i), '0, '0);
        end
    endtask

    initial begin
        vecs[0] = '{"rst_clear",    1'b1, 1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0};
        vecs[1] = '{"write_r8",     1'b0, 1'b1, 5'd8,  32'hDEADBEEF, 5'd8,  5'd7,  32'hDEADBEEF, 32'h0};
        vecs[2] = '{"we0_ignored",  1'b0, 1'b0, 5'd9,  32'h55555555, 5'd9,  5'd8,  32'h0,        32'hDEADBEEF};
        vecs[3] = '{"zero_reg",     1'b0, 1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  32'h0,        32'h0};
        vecs[4] = '{"rst_priority", 1'b1, 1'b1, 5'd5,  32'h12345678, 5'd5,  5'd8,  32'h0,        32'h0};
        vecs[5] = '{"r3_first",     1'b0, 1'b1, 5'd3,  32'h00000011, 5'd3,  5'd3,  32'h11,       32'h11};
        vecs[6] = '{"r3_overwrite", 1'b0, 1'b1, 5'd3,  32'h00000022, 5'd3,  5'd3,  32'h22,       32'h22};
        vecs[7] = '{"write_r31",    1'b0, 1'b1, 5'd31, 32'hCAFEF00D, 5'd31, 5'd3,  32'hCAFEF00D, 32'h22};
        vecs[8] = '{"write_r1",     1'b0, 1'b1, 5'd1,  32'h00000001, 5'd1,  5'd30, 32'h1,        32'h0};

        // Reset then full address sweep
        do_cycle(1'b1, 1'b0, '0, '0);
        reset_sweep("reset_sweep");

        // Directed vector table: one edge per record, read checked after it
        for (int v = 0; v < 9; v++) begin
            do_cycle(vecs[v].rst, vecs[v].wen, vecs[v].wa, vecs[v].wd);
            read_check(vecs[v].name, vecs[v].ra, vecs[v].rb, vecs[v].exp_a, vecs[v].exp_b);
        end
        // Neighbours of reg 8 untouched after its write
        do_cycle(1'b0, 1'b1, 5'd8, 32'hDEADBEEF);
        read_check("r8_neighbours", 5'd7, 5'd9, 32'h0, 32'h0);

        // Same-cycle read of the write target
        do_cycle(1'b0, 1'b1, 5'd4, 32'hA);
        @(negedge clk);
        we      = 1'b1;
        waddr   = 5'd4;
        wdata   = 32'hB;
        raddr_a = 5'd4;
        raddr_b = 5'd4;
        #1;
        check("same_cycle_pre_a", rdata_a, BYPASS ? 32'hB : 32'hA);
        check("same_cycle_pre_b", rdata_b, BYPASS ? 32'hB : 32'hA);
        @(posedge clk);
        #1;
        we = 1'b0;
        #1;
        check("same_cycle_post", rdata_a, 32'hB);

        // Forwarding suppressed while reset is high: stored value shows, then cleared
        @(negedge clk);
        reset   = 1'b1;
        we      = 1'b1;
        waddr   = 5'd4;
        wdata   = 32'hC;
        raddr_a = 5'd4;
        #1;
        check("bypass_off_in_reset", rdata_a, 32'hB);
        @(posedge clk);
        #1;
        reset = 1'b0;
        we    = 1'b0;
        #1;
        check("reset_clears_r4", rdata_a, 32'h0);

        // Randomized phase against the array model
        for (int i = 0; i < N; i++) model[i] = '0;
        for (int it = 0; it < 400; it++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 39) == 0);
            we    = ($urandom_range(0, 3) != 0);
            waddr = AW'($urandom_range(0, N - 1));
            wdata = $urandom;
            raddr_a = ($urandom_range(0, 2) == 0) ? waddr : AW'($urandom_range(0, N - 1));
            raddr_b = ($urandom_range(0, 2) == 0) ? waddr : AW'($urandom_range(0, N - 1));
            #1;
            check("rand_pre_a", rdata_a, exp_read(raddr_a));
            check("rand_pre_b", rdata_b, exp_read(raddr_b));
            @(posedge clk);
            if (reset) begin
                for (int i = 0; i < N; i++) model[i] = '0;
            end else if (we && (waddr != 0)) begin
                model[waddr] = wdata;
            end
            #1;
            reset = 1'b0;
            we    = 1'b0;
            #1;
            check("rand_post_a", rdata_a, model[raddr_a]);
            check("rand_post_b", rdata_b, model[raddr_b]);
        end

        // Reset after many writes clears every register, then first write works
        do_cycle(1'b1, 1'b0, '0, '0);
        reset_sweep("final_reset_sweep");
        do_cycle(1'b0, 1'b1, 5'd17, 32'h0BADF00D);
        read_check("post_reset_write", 5'd17, 5'd16, 32'h0BADF00D, 32'h0);

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
